camera_frame_reader: RTL and testbench

Downstream companion of the camera DDR write path. Once a full camera frame has been written into one of the two DDR ping-pong buffers, this block accepts a start command from the controller. It then fetches the frame through an AXI4 read master in 16-beat × 32-bit bursts, repacks each burst into one 512-bit word, and streams the words to the accelerator. It signals frame completion back to the controller with a valid/ready handshake.

---
 rtl/camera_frame_reader.sv | 139 +++++++++++++
 tb/tb_camera_frame_reader.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/camera_frame_reader.sv
// camera_frame_reader: reads one camera frame from a DDR ping-pong buffer as
// 16-beat x 32-bit AXI4 bursts and streams each burst as one 512-bit word.
module camera_frame_reader #(
    parameter logic [31:0] BUF0_ADDR        = 32'h2BC0_0000,
    parameter logic [31:0] BUF1_ADDR        = 32'h2BE0_0000,
    parameter int          BURSTS_PER_FRAME = 9600
) (
    input  logic         clk,
    input  logic         aresetn,
    input  logic         ddr_read_start_valid,
    output logic         ddr_read_start_ready,
    input  logic         odd_even_flag,
    output logic         ddr_read_finish_valid,
    input  logic         ddr_read_finish_ready,
    output logic         rd_error,
    output logic [0:0]   M_AXI_ARID,
    output logic [31:0]  M_AXI_ARADDR,
    output logic [7:0]   M_AXI_ARLEN,
    output logic [2:0]   M_AXI_ARSIZE,
    output logic [1:0]   M_AXI_ARBURST,
    output logic         M_AXI_ARLOCK,
    output logic [3:0]   M_AXI_ARCACHE,
    output logic [2:0]   M_AXI_ARPROT,
    output logic [3:0]   M_AXI_ARQOS,
    output logic [0:0]   M_AXI_ARUSER,
    output logic         M_AXI_ARVALID,
    input  logic         M_AXI_ARREADY,
    input  logic [0:0]   M_AXI_RID,
    input  logic [31:0]  M_AXI_RDATA,
    input  logic [1:0]   M_AXI_RRESP,
    input  logic         M_AXI_RLAST,
    input  logic [0:0]   M_AXI_RUSER,
    input  logic         M_AXI_RVALID,
    output logic         M_AXI_RREADY,
    output logic [511:0] frame_out_data,
    output logic         frame_out_valid,
    input  logic         frame_out_ready,
    output logic         frame_out_last
);

    // Every handshake transfers on a rising edge where valid && ready; a valid
    // never drops and its payload never changes until that transfer happens.
    typedef enum logic [2:0] {S_IDLE, S_AR, S_RD, S_OUT, S_DONE} state_t;

    localparam logic [13:0] LAST_BURST = 14'(BURSTS_PER_FRAME - 1);

    state_t         state, state_nxt;
    logic [31:0]    addr;
    logic [13:0]    burst_cnt;
    logic [3:0]     beat_cnt;
    logic [511:0]   data_reg;
    logic           err_q;
    logic           is_last;
    logic           unused_rsig;

    assign unused_rsig   = ^{M_AXI_RID, M_AXI_RUSER};

    assign M_AXI_ARID    = 1'b0;
    assign M_AXI_ARLEN   = 8'd15;
    assign M_AXI_ARSIZE  = 3'b010;
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = 4'b0011;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARQOS   = 4'b0000;
    assign M_AXI_ARUSER  = 1'b1;

    assign M_AXI_ARADDR   = addr;
    assign frame_out_data = data_reg;
    assign rd_error       = err_q;
    assign is_last        = (burst_cnt == LAST_BURST);
    assign frame_out_last = (state == S_OUT) && is_last;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt             = state;
        ddr_read_start_ready  = 1'b0;
        M_AXI_ARVALID         = 1'b0;
        M_AXI_RREADY          = 1'b0;
        frame_out_valid       = 1'b0;
        ddr_read_finish_valid = 1'b0;
        case (state)
            S_IDLE: begin
                ddr_read_start_ready = 1'b1;
                if (ddr_read_start_valid) state_nxt = S_AR;
            end
            S_AR: begin
                M_AXI_ARVALID = 1'b1;
                if (M_AXI_ARREADY) state_nxt = S_RD;
            end
            S_RD: begin
                // The burst ends on the 16th beat whatever RLAST says.
                M_AXI_RREADY = 1'b1;
                if (M_AXI_RVALID && beat_cnt == 4'd15) state_nxt = S_OUT;
            end
            S_OUT: begin
                frame_out_valid = 1'b1;
                if (frame_out_ready) state_nxt = is_last ? S_DONE : S_AR;
            end
            S_DONE: begin
                ddr_read_finish_valid = 1'b1;
                if (ddr_read_finish_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            addr      <= 32'd0;
            burst_cnt <= 14'd0;
            beat_cnt  <= 4'd0;
            data_reg  <= '0;
            err_q     <= 1'b0;
        end else begin
            if (state == S_IDLE && ddr_read_start_valid) begin
                addr      <= odd_even_flag ? BUF1_ADDR : BUF0_ADDR;
                burst_cnt <= 14'd0;
                beat_cnt  <= 4'd0;
                err_q     <= 1'b0;
            end
            if (state == S_RD && M_AXI_RVALID) begin
                data_reg[{beat_cnt, 5'd0} +: 32] <= M_AXI_RDATA;
                beat_cnt <= beat_cnt + 4'd1;
                if (M_AXI_RRESP != 2'b00 || M_AXI_RLAST != (beat_cnt == 4'd15))
                    err_q <= 1'b1;
            end
            if (state == S_OUT && frame_out_ready && !is_last) begin
                burst_cnt <= burst_cnt + 14'd1;
                addr      <= addr + 32'd64;
            end
        end
    end

endmodule

// File: tb/tb_camera_frame_reader.sv
// Bench for camera_frame_reader: AXI read slave model, output monitor and
// frame-level reference model built from the buffer address rules.
module tb_camera_frame_reader;

    localparam int          N  = 3;
    localparam logic [31:0] B0 = 32'h2BC0_0000;
    localparam logic [31:0] B1 = 32'h2BE0_0000;

    logic         clk = 1'b0;
    logic         aresetn = 1'b0;
    logic         ddr_read_start_valid, ddr_read_start_ready, odd_even_flag;
    logic         ddr_read_finish_valid, ddr_read_finish_ready, rd_error;
    logic [0:0]   M_AXI_ARID, M_AXI_ARUSER, M_AXI_RID, M_AXI_RUSER;
    logic [31:0]  M_AXI_ARADDR, M_AXI_RDATA;
    logic [7:0]   M_AXI_ARLEN;
    logic [2:0]   M_AXI_ARSIZE, M_AXI_ARPROT;
    logic [1:0]   M_AXI_ARBURST, M_AXI_RRESP;
    logic         M_AXI_ARLOCK, M_AXI_ARVALID, M_AXI_ARREADY;
    logic [3:0]   M_AXI_ARCACHE, M_AXI_ARQOS;
    logic         M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;
    logic [511:0] frame_out_data;
    logic         frame_out_valid, frame_out_ready, frame_out_last;

    always #5 clk = ~clk;

    camera_frame_reader #(
        .BUF0_ADDR(B0), .BUF1_ADDR(B1), .BURSTS_PER_FRAME(N)
    ) dut (
        .clk(clk), .aresetn(aresetn),
        .ddr_read_start_valid(ddr_read_start_valid), .ddr_read_start_ready(ddr_read_start_ready),
        .odd_even_flag(odd_even_flag),
        .ddr_read_finish_valid(ddr_read_finish_valid), .ddr_read_finish_ready(ddr_read_finish_ready),
        .rd_error(rd_error),
        .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
        .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARLOCK(M_AXI_ARLOCK),
        .M_AXI_ARCACHE(M_AXI_ARCACHE), .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARQOS(M_AXI_ARQOS),
        .M_AXI_ARUSER(M_AXI_ARUSER), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RID(M_AXI_RID), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RUSER(M_AXI_RUSER), .M_AXI_RVALID(M_AXI_RVALID),
        .M_AXI_RREADY(M_AXI_RREADY),
        .frame_out_data(frame_out_data), .frame_out_valid(frame_out_valid),
        .frame_out_ready(frame_out_ready), .frame_out_last(frame_out_last)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [511:0] exp_q[$];
    logic         exp_last_q[$];
    logic [31:0]  exp_ar_q[$];

    // per-frame stimulus configuration, owned by the main sequence
    int          frame_seq = 0;
    int          cfg_ar_delay = 0, cfg_stall_word = -1;
    int          cfg_err_burst = -1, cfg_err_beat = 0, cfg_early_burst = -1;
    bit          cfg_gap = 0, cfg_rdy_rand = 0, cfg_linear = 0;
    logic [31:0] cfg_seed = 0, cfg_base = 0;

    int out_count = 0;     // written by the monitor only
    int slv_accepted = 0;  // written by the slave only

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (cfg_linear) return (a - cfg_base) >> 2;
        return (a * 32'h9E37_79B1) ^ cfg_seed;
    endfunction

    // AXI read slave: one outstanding burst, optional AR delay, gaps, error injection
    initial begin : axi_slave
        int phase, wait_cnt, beat, burst_idx, seen_seq;
        logic [31:0] cur_addr, held_addr;
        phase = 0; wait_cnt = 0; beat = 0; burst_idx = 0; seen_seq = 0;
        cur_addr = 0; held_addr = 0;
        M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0;
        M_AXI_RLAST = 0; M_AXI_RID = 0; M_AXI_RUSER = 0;
        forever begin
            @(posedge clk); #1;
            if (M_AXI_RVALID && aresetn) begin beat++; slv_accepted++; end
            M_AXI_RVALID = 0; M_AXI_RLAST = 0; M_AXI_RRESP = 0;
            if (frame_seq != seen_seq) begin
                seen_seq = frame_seq; burst_idx = 0; slv_accepted = 0;
            end
            if (!aresetn) begin
                phase = 0; wait_cnt = 0; beat = 0; M_AXI_ARREADY = 0;
                continue;
            end
            if (phase == 1) begin
                check("no_ar_while_reading", M_AXI_ARVALID, 0);
                if (beat == 16) begin
                    check("out_valid_after_rlast", frame_out_valid, 1);
                    phase = 0; burst_idx++;
                end else if (!(cfg_gap && $urandom_range(0, 2) == 0)) begin
                    M_AXI_RVALID = 1;
                    M_AXI_RDATA  = mem_word(cur_addr + 32'(4 * beat));
                    M_AXI_RLAST  = (burst_idx == cfg_early_burst) ? (beat == 14) : (beat == 15);
                    M_AXI_RRESP  = (burst_idx == cfg_err_burst && beat == cfg_err_beat) ? 2'b10 : 2'b00;
                end
            end else if (M_AXI_ARREADY) begin
                M_AXI_ARREADY = 0; phase = 1; beat = 0;
            end else if (M_AXI_ARVALID) begin
                if (wait_cnt == 0) begin
                    held_addr = M_AXI_ARADDR;
                    if (exp_ar_q.size() == 0) check("araddr_unexpected", held_addr, 0);
                    else check("araddr", held_addr, exp_ar_q.pop_front());
                    check("no_read_ahead", burst_idx, out_count);
                end else begin
                    check("araddr_hold", M_AXI_ARADDR, held_addr);
                end
                if (wait_cnt >= cfg_ar_delay) begin
                    M_AXI_ARREADY = 1; cur_addr = held_addr; wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // output ready driver: optional 10-cycle stall on one word, optional random ready
    initial begin : ready_drv
        int stall_left, stalled_seq;
        stall_left = 0; stalled_seq = -1;
        frame_out_ready = 0;
        forever begin
            @(posedge clk); #1;
            if (frame_out_valid && out_count == cfg_stall_word && stalled_seq != frame_seq) begin
                stall_left = 10; stalled_seq = frame_seq;
            end
            if (stall_left > 0) begin
                frame_out_ready = 0; stall_left--;
            end else begin
                frame_out_ready = cfg_rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    // monitor: pops the expected queue on every accepted output word
    initial begin : monitor
        logic [511:0] hold_data;
        logic         hold_last;
        bit           holding;
        int           seen_seq;
        holding = 0; seen_seq = 0; hold_data = 0; hold_last = 0;
        forever begin
            @(negedge clk);
            if (frame_seq != seen_seq) begin seen_seq = frame_seq; out_count = 0; holding = 0; end
            if (!aresetn) begin holding = 0; continue; end
            if (holding) begin
                check("out_valid_hold", frame_out_valid, 1);
                check("out_data_hold", frame_out_data, hold_data);
                check("out_last_hold", frame_out_last, hold_last);
            end
            holding = 0;
            if (frame_out_valid) begin
                if (frame_out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("out_unexpected_word", frame_out_valid, 0);
                    end else begin
                        check("out_data", frame_out_data, exp_q.pop_front());
                        check("out_last", frame_out_last, exp_last_q.pop_front());
                    end
                    out_count++;
                end else begin
                    holding = 1; hold_data = frame_out_data; hold_last = frame_out_last;
                end
            end
        end
    end

    task automatic set_cfg(input int ar_delay, input bit gap, input bit rdy_rand, input int stall_word,
                           input int err_burst, input int err_beat, input int early_burst);
        cfg_ar_delay = ar_delay; cfg_gap = gap; cfg_rdy_rand = rdy_rand; cfg_stall_word = stall_word;
        cfg_err_burst = err_burst; cfg_err_beat = err_beat; cfg_early_burst = early_burst;
    endtask

    // reference model: word k of a frame is the 64 bytes at base + 64k, lowest address in bits [31:0]
    task automatic start_frame(input bit odd, input bit keep_start);
        logic [511:0] w;
        int t;
        frame_seq++;
        cfg_base = odd ? B1 : B0;
        cfg_seed = $urandom;
        for (int k = 0; k < N; k++) begin
            exp_ar_q.push_back(cfg_base + 32'(64 * k));
            w = '0;
            for (int j = 0; j < 16; j++) w[32*j +: 32] = mem_word(cfg_base + 32'(64 * k + 4 * j));
            exp_q.push_back(w);
            exp_last_q.push_back(k == N - 1);
        end
        t = 0;
        while (!ddr_read_start_ready && t < 100) begin @(posedge clk); #1; t++; end
        check("start_ready_idle", ddr_read_start_ready, 1);
        ddr_read_start_valid = 1; odd_even_flag = odd;
        @(posedge clk); #1;
        check("arvalid_after_start", M_AXI_ARVALID, 1);
        check("start_ready_busy", ddr_read_start_ready, 0);
        check("rd_error_cleared", rd_error, 0);
        ddr_read_start_valid = keep_start;
        odd_even_flag = ~odd;
    endtask

    task automatic finish_frame(input int hold, input bit exp_err);
        int t;
        t = 0;
        while (!ddr_read_finish_valid && t < 3000) begin @(posedge clk); #1; t++; end
        check("finish_seen", ddr_read_finish_valid, 1);
        ddr_read_start_valid = 0;
        check("rd_error_done", rd_error, exp_err);
        check("words_drained", exp_q.size(), 0);
        check("ar_drained", exp_ar_q.size(), 0);
        for (int i = 0; i < hold; i++) begin
            check("finish_valid_held", ddr_read_finish_valid, 1);
            check("start_ready_in_done", ddr_read_start_ready, 0);
            @(posedge clk); #1;
        end
        ddr_read_finish_ready = 1;
        check("finish_valid_at_ready", ddr_read_finish_valid, 1);
        @(posedge clk); #1;
        ddr_read_finish_ready = 0;
        check("finish_single_pulse", ddr_read_finish_valid, 0);
        check("idle_after_finish", ddr_read_start_ready, 1);
        check("rd_error_kept", rd_error, exp_err);
    endtask

    task automatic check_reset_outputs();
        check("rst_start_ready", ddr_read_start_ready, 1);
        check("rst_arvalid", M_AXI_ARVALID, 0);
        check("rst_rready", M_AXI_RREADY, 0);
        check("rst_out_valid", frame_out_valid, 0);
        check("rst_finish_valid", ddr_read_finish_valid, 0);
        check("rst_araddr", M_AXI_ARADDR, 0);
        check("rst_out_data", frame_out_data, 0);
        check("rst_out_last", frame_out_last, 0);
        check("rst_rd_error", rd_error, 0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int t;
        bit odd, err;
        ddr_read_start_valid = 0; odd_even_flag = 0; ddr_read_finish_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk); aresetn = 1;
        @(posedge clk); #1;
        check("ar_const_fields",
              {M_AXI_ARID, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARLOCK,
               M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS, M_AXI_ARUSER},
              {1'b0, 8'd15, 3'b010, 2'b01, 1'b0, 4'b0011, 3'b000, 4'b0000, 1'b1});

        // even buffer, linear memory contents, no stalls
        cfg_linear = 1;
        set_cfg(0, 0, 0, -1, -1, 0, -1);
        start_frame(0, 0);
        finish_frame(0, 0);
        cfg_linear = 0;

        // odd buffer, slow ARREADY, gapped RVALID, stalled word 1, start held high
        set_cfg(5, 1, 0, 1, -1, 0, -1);
        start_frame(1, 1);
        finish_frame(0, 0);

        // RRESP error on beat 7 of burst 1
        set_cfg(0, 0, 0, -1, 1, 7, -1);
        start_frame(0, 0);
        finish_frame(0, 1);

        // early RLAST on beat 14 of burst 0
        set_cfg(0, 0, 0, -1, -1, 0, 0);
        start_frame(1, 0);
        finish_frame(0, 1);

        // reset while 8 beats of the first burst are in
        set_cfg(0, 0, 0, -1, -1, 0, -1);
        start_frame(0, 0);
        t = 0;
        while (slv_accepted < 8 && t < 200) begin @(negedge clk); t++; end
        check("reached_8_beats", slv_accepted, 8);
        aresetn = 0;
        #1;
        check_reset_outputs();
        exp_q.delete(); exp_last_q.delete(); exp_ar_q.delete();
        repeat (2) @(negedge clk);
        aresetn = 1;
        @(posedge clk); #1;
        start_frame(0, 0);
        finish_frame(0, 0);

        // finish_ready held off for 20 cycles
        set_cfg(1, 0, 0, -1, -1, 0, -1);
        start_frame(1, 0);
        finish_frame(20, 0);

        // randomized frames
        for (int f = 0; f < 8; f++) begin
            odd = 1'($urandom_range(0, 1));
            err = ($urandom_range(0, 2) == 0);
            set_cfg($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3) == 0 ? int'($urandom_range(0, N - 1)) : -1,
                    err ? int'($urandom_range(0, N - 1)) : -1, $urandom_range(0, 15), -1);
            start_frame(odd, 1'($urandom_range(0, 1)));
            finish_frame($urandom_range(0, 3), err);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
